shared_unidirectional_bus: RTL and testbench

Parametrised N-source, single-destination unidirectional bus with arbitration, a registered output stage and valid/ready handshaking on both sides. It generalises the lab's fixed 4-bit unidirectional bus in width, source count and arbitration mode. It sits between register-file/ALU result producers and a single consumer such as a writeback or memory port. Any number of sources may request in a cycle; exactly one is granted per accepted transfer, and each transfer is tagged with its source index.

---
 rtl/shared_unidirectional_bus.sv | 77 +++++++
 tb/tb_shared_unidirectional_bus.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_unidirectional_bus.sv
// N-source, single-destination bus: arbitrated grant into one output register,
// valid/ready on both sides, and a wrapping count of destination handshakes.
module shared_unidirectional_bus #(
  parameter int WIDTH   = 4,
  parameter int NUM_SRC = 4,
  parameter int RR_MODE = 1,
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     bus_valid,
  output logic [WIDTH-1:0]         bus_data,
  output logic [SW-1:0]            bus_src,
  input  logic                     bus_ready,
  output logic [15:0]              xfer_count
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] ptr_next;
  logic          grant_any;
  logic          can_load;
  logic          load;
  int            idx;

  // The register may be refilled in the same cycle the destination drains it.
  assign can_load = !bus_valid || bus_ready;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (RR_MODE != 0) ? int'(ptr) + k : k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!grant_any && src_valid[idx[SW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[SW-1:0];
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (!rst && can_load && grant_any) src_ready[grant_idx] = 1'b1;
  end

  assign load     = |src_ready;
  assign ptr_next = (grant_idx == SW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_valid  <= 1'b0;
      bus_data   <= '0;
      bus_src    <= '0;
      xfer_count <= '0;
      ptr        <= '0;
    end else begin
      if (load) begin
        bus_valid <= 1'b1;
        bus_data  <= src_data[grant_idx*WIDTH +: WIDTH];
        bus_src   <= grant_idx;
        if (RR_MODE != 0) ptr <= ptr_next;
      end else if (bus_ready) begin
        bus_valid <= 1'b0;
      end
      if (bus_valid && bus_ready) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_shared_unidirectional_bus.sv
// Directed bench: one round-robin instance and one fixed-priority instance
// sharing the same stimulus, each checked against hand-computed values.
module tb_shared_unidirectional_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_valid;
  logic [15:0] src_data;
  logic        bus_ready;

  logic [3:0]  src_ready,  fp_src_ready;
  logic        bus_valid,  fp_bus_valid;
  logic [3:0]  bus_data,   fp_bus_data;
  logic [1:0]  bus_src,    fp_bus_src;
  logic [15:0] xfer_count, fp_xfer_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shared_unidirectional_bus #(.WIDTH(4), .NUM_SRC(4), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_src(bus_src), .bus_ready(bus_ready), .xfer_count(xfer_count)
  );

  shared_unidirectional_bus #(.WIDTH(4), .NUM_SRC(4), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_ready(fp_src_ready), .bus_valid(fp_bus_valid), .bus_data(fp_bus_data),
    .bus_src(fp_bus_src), .bus_ready(bus_ready), .xfer_count(fp_xfer_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_valid = 4'b0000;
    src_data  = 16'h0000;
    bus_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    src_valid = 4'b1111;
    src_data  = 16'hDCBA;
    bus_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (src_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_src_ready: got %b expected 0000", src_ready);
    end
    n_checks++;
    if (bus_valid !== 1'b0 || bus_data !== 4'h0 || bus_src !== 2'd0) begin
      n_fail++; $display("FAIL reset_bus: got v=%b d=%h s=%0d expected v=0 d=0 s=0", bus_valid, bus_data, bus_src);
    end
    n_checks++;
    if (xfer_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", xfer_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (src_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", src_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_data [4];
    exp_data[0] = 4'hA; exp_data[1] = 4'hB; exp_data[2] = 4'hC; exp_data[3] = 4'hD;
    do_reset();
    src_data  = 16'hDCBA;
    src_valid = 4'b1111;
    bus_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (src_ready !== (4'b0001 << (i % 4))) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, src_ready, 4'b0001 << (i % 4));
      end
      tick();
      n_checks++;
      if (bus_valid !== 1'b1 || bus_src !== 2'(i % 4) || bus_data !== exp_data[i % 4]) begin
        n_fail++; $display("FAIL rr_bus[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                           i, bus_valid, bus_src, bus_data, i % 4, exp_data[i % 4]);
      end
      n_checks++;
      if (xfer_count !== 16'(i)) begin
        n_fail++; $display("FAIL rr_count[%0d]: got %0d expected %0d", i, xfer_count, i);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    src_data  = 16'h7351;
    src_valid = 4'b1010;
    bus_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fp_src_ready !== 4'b0010) begin
        n_fail++; $display("FAIL fp_ready[%0d]: got %b expected 0010", i, fp_src_ready);
      end
      tick();
      n_checks++;
      if (fp_bus_src !== 2'd1 || fp_bus_data !== 4'h5) begin
        n_fail++; $display("FAIL fp_bus[%0d]: got s=%0d d=%h expected s=1 d=5", i, fp_bus_src, fp_bus_data);
      end
      n_checks++;
      if (bus_src !== ((i % 2 == 0) ? 2'd1 : 2'd3)) begin
        n_fail++; $display("FAIL rr_pair[%0d]: got s=%0d expected %0d", i, bus_src, (i % 2 == 0) ? 1 : 3);
      end
    end
    src_valid = 4'b1000;
    #1;
    n_checks++;
    if (fp_src_ready !== 4'b1000) begin
      n_fail++; $display("FAIL fp_ready_drop: got %b expected 1000", fp_src_ready);
    end
    tick();
    n_checks++;
    if (fp_bus_src !== 2'd3 || fp_bus_data !== 4'h7 || fp_bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL fp_bus_drop: got v=%b s=%0d d=%h expected v=1 s=3 d=7", fp_bus_valid, fp_bus_src, fp_bus_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    src_data  = 16'h0509;
    src_valid = 4'b0100;
    bus_ready = 1'b0;
    #1;
    n_checks++;
    if (src_ready !== 4'b0100) begin
      n_fail++; $display("FAIL bp_load_ready: got %b expected 0100", src_ready);
    end
    tick();
    src_valid = 4'b0001;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (src_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, src_ready);
      end
      n_checks++;
      if (bus_valid !== 1'b1 || bus_data !== 4'h5 || bus_src !== 2'd2) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d expected v=1 d=5 s=2", i, bus_valid, bus_data, bus_src);
      end
      tick();
    end
    bus_ready = 1'b1;
    #1;
    n_checks++;
    if (src_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_reload_ready: got %b expected 0001", src_ready);
    end
    tick();
    src_valid = 4'b0000;
    n_checks++;
    if (bus_valid !== 1'b1 || bus_data !== 4'h9 || bus_src !== 2'd0 || xfer_count !== 16'd1) begin
      n_fail++; $display("FAIL bp_reload: got v=%b d=%h s=%0d c=%0d expected v=1 d=9 s=0 c=1",
                         bus_valid, bus_data, bus_src, xfer_count);
    end
    tick();
    n_checks++;
    if (bus_valid !== 1'b0 || xfer_count !== 16'd2) begin
      n_fail++; $display("FAIL bp_drain: got v=%b c=%0d expected v=0 c=2", bus_valid, xfer_count);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    src_data  = 16'hDCBA;
    src_valid = 4'b1111;
    bus_ready = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    n_checks++;
    if (xfer_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL wrap_pre: got %h expected fffe", xfer_count);
    end
    tick();
    tick();
    n_checks++;
    if (xfer_count !== 16'h0000 || bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap: got c=%h v=%b expected c=0000 v=1", xfer_count, bus_valid);
    end
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (src_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_ready: got %b expected 0000", src_ready);
    end
    tick();
    n_checks++;
    if (bus_valid !== 1'b0 || xfer_count !== 16'd0) begin
      n_fail++; $display("FAIL midrst: got v=%b c=%0d expected v=0 c=0", bus_valid, xfer_count);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
